// File: rtl/mitll_gaten_t.sv
// N-input clocked SFQ gate emulated on a sampling clock. Data, gate clock and output are
// toggle-encoded pulse lines, and the gate function is selectable at runtime (OR/AND/XOR/majority).
module mitll_gaten_t #(
  parameter int N  = 4,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  din,
  input  logic          gclk,
  input  logic [1:0]    mode,
  input  logic          err_clr,
  output logic          out,
  output logic [N-1:0]  err_dbl,
  output logic [CW-1:0] eval_cnt
);

  localparam int PW = $clog2(N + 1);

  logic [N-1:0]  r_din_q;
  logic          r_gclk_q;
  logic [N-1:0]  r_st;
  logic          r_out;
  logic [N-1:0]  r_err;
  logic [CW-1:0] r_cnt;

  logic [N-1:0]  w_dpulse;
  logic          w_gpulse;
  logic          w_f;
  logic [N-1:0]  w_st_nxt;
  logic [N-1:0]  w_err_nxt;
  logic          w_out_nxt;
  logic [CW-1:0] w_cnt_nxt;

  // Gate function over the stored channel bits; majority means strictly more than N/2 stored.
  function automatic logic f_eval(input logic [1:0] m, input logic [N-1:0] s);
    logic [PW-1:0] c;
    logic          r;
    c = '0;
    for (int i = 0; i < N; i++) begin
      c = c + PW'(s[i]);
    end
    case (m)
      2'd0:    r = |s;
      2'd1:    r = &s;
      2'd2:    r = ^s;
      2'd3:    r = (c > PW'(N / 2));
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  assign w_dpulse = din ^ r_din_q;
  assign w_gpulse = gclk ^ r_gclk_q;
  assign w_f      = f_eval(mode, r_st);

  // Next-state logic. A data pulse coinciding with gclk lands in the next period and is never a double pulse.
  always_comb begin
    w_st_nxt  = r_st | w_dpulse;
    w_out_nxt = r_out;
    w_cnt_nxt = r_cnt;
    if (w_gpulse) begin
      w_st_nxt  = w_dpulse;
      w_out_nxt = r_out ^ w_f;
      w_cnt_nxt = r_cnt + CW'(1);
    end else begin
      w_st_nxt  = r_st | w_dpulse;
    end
    if (err_clr) begin
      w_err_nxt = '0;
    end else begin
      w_err_nxt = r_err;
    end
    w_err_nxt = w_err_nxt | (w_dpulse & r_st & {N{~w_gpulse}});
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_din_q  <= '0;
      r_gclk_q <= 1'b0;
      r_st     <= '0;
      r_out    <= 1'b0;
      r_err    <= '0;
      r_cnt    <= '0;
    end else begin
      r_din_q  <= din;
      r_gclk_q <= gclk;
      r_st     <= w_st_nxt;
      r_out    <= w_out_nxt;
      r_err    <= w_err_nxt;
      r_cnt    <= w_cnt_nxt;
    end
  end

  assign out      = r_out;
  assign err_dbl  = r_err;
  assign eval_cnt = r_cnt;

endmodule

// File: tb/tb_mitll_gaten_t.sv
// Directed bench for mitll_gaten_t: a CW=8 and a CW=2 instance share all inputs.
module tb_mitll_gaten_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] din;
  logic       gclk;
  logic [1:0] mode;
  logic       err_clr;
  logic       out_a, out_b;
  logic [3:0] err_a, err_b;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;

  int n_checks = 0;
  int n_errors = 0;

  mitll_gaten_t #(.N(4), .CW(8)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .gclk(gclk), .mode(mode), .err_clr(err_clr),
    .out(out_a), .err_dbl(err_a), .eval_cnt(cnt_a)
  );

  mitll_gaten_t #(.N(4), .CW(2)) dut_w (
    .clk(clk), .rst_n(rst_n), .din(din), .gclk(gclk), .mode(mode), .err_clr(err_clr),
    .out(out_b), .err_dbl(err_b), .eval_cnt(cnt_b)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; din = 4'b0000; gclk = 1'b0; err_clr = 1'b0; mode = 2'd0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; din = 4'b0000; gclk = 1'b0; err_clr = 1'b0; mode = 2'd0;
    #2;
    n_checks++;
    if ({out_a, err_a, cnt_a} !== 13'd0) begin
      n_errors++; $display("FAIL reset_state: got out=%0b err=%b cnt=%0d, expected 0/0000/0", out_a, err_a, cnt_a);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_or_basic();
    do_reset();
    tick();
    din[0] = ~din[0]; tick();
    tick(); tick();
    gclk = ~gclk; tick();
    n_checks++;
    if (out_a !== 1'b1 || cnt_a !== 8'd1) begin
      n_errors++; $display("FAIL or_first_eval: got out=%0b cnt=%0d, expected 1/1", out_a, cnt_a);
    end
    gclk = ~gclk; tick();
    n_checks++;
    if (out_a !== 1'b1 || cnt_a !== 8'd2) begin
      n_errors++; $display("FAIL or_empty_eval: got out=%0b cnt=%0d, expected 1/2", out_a, cnt_a);
    end
  endtask

  task automatic test_function_sweep();
    logic [1:0] t_mode [7] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3};
    logic [3:0] t_st   [7] = '{4'b0011, 4'b0011, 4'b1111, 4'b0011, 4'b0001, 4'b0011, 4'b0111};
    logic       t_exp  [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int k = 0; k < 7; k++) begin
      do_reset();
      mode = t_mode[k];
      din = din ^ t_st[k]; tick();
      gclk = ~gclk; tick();
      n_checks++;
      if (out_a !== t_exp[k] || cnt_a !== 8'd1) begin
        n_errors++;
        $display("FAIL sweep_%0d mode=%0d st=%b: got out=%0b cnt=%0d, expected %0b/1", k, t_mode[k], t_st[k], out_a, cnt_a, t_exp[k]);
      end
    end
  endtask

  task automatic test_double_pulse();
    do_reset();
    din[2] = ~din[2]; tick();
    n_checks++;
    if (err_a !== 4'b0000) begin
      n_errors++; $display("FAIL dbl_first_pulse: got err=%b expected 0000", err_a);
    end
    tick();
    din[2] = ~din[2]; tick();
    n_checks++;
    if (err_a !== 4'b0100) begin
      n_errors++; $display("FAIL dbl_set: got err=%b expected 0100", err_a);
    end
    tick();
    gclk = ~gclk; tick();
    n_checks++;
    if (out_a !== 1'b1 || err_a !== 4'b0100) begin
      n_errors++; $display("FAIL dbl_eval: got out=%0b err=%b, expected 1/0100", out_a, err_a);
    end
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    n_checks++;
    if (err_a !== 4'b0000) begin
      n_errors++; $display("FAIL dbl_clear: got err=%b expected 0000", err_a);
    end
    din[3] = ~din[3]; tick();
    din[3] = ~din[3]; err_clr = 1'b1; tick(); err_clr = 1'b0;
    n_checks++;
    if (err_a !== 4'b1000) begin
      n_errors++; $display("FAIL dbl_clear_race: got err=%b expected 1000", err_a);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    din[1] = ~din[1]; gclk = ~gclk; tick();
    n_checks++;
    if (out_a !== 1'b0 || cnt_a !== 8'd1 || err_a !== 4'b0000) begin
      n_errors++; $display("FAIL simul_excluded: got out=%0b cnt=%0d err=%b, expected 0/1/0000", out_a, cnt_a, err_a);
    end
    din[1] = ~din[1]; gclk = ~gclk; tick();
    n_checks++;
    if (out_a !== 1'b1 || cnt_a !== 8'd2 || err_a !== 4'b0000) begin
      n_errors++; $display("FAIL simul_no_dbl: got out=%0b cnt=%0d err=%b, expected 1/2/0000", out_a, cnt_a, err_a);
    end
    gclk = ~gclk; tick();
    n_checks++;
    if (out_a !== 1'b0 || cnt_a !== 8'd3) begin
      n_errors++; $display("FAIL simul_next_eval: got out=%0b cnt=%0d, expected 0/3", out_a, cnt_a);
    end
  endtask

  task automatic test_wrap();
    logic [1:0] exp_w [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    do_reset();
    for (int k = 0; k < 5; k++) begin
      gclk = ~gclk; tick();
      n_checks++;
      if (cnt_b !== exp_w[k] || cnt_a !== 8'(k + 1)) begin
        n_errors++; $display("FAIL wrap_%0d: got cnt2=%0d cnt8=%0d, expected %0d/%0d", k, cnt_b, cnt_a, exp_w[k], k + 1);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    din[1] = ~din[1]; tick();
    din[1] = ~din[1]; tick();
    din[0] = ~din[0]; tick();
    gclk = ~gclk; tick();
    din[0] = ~din[0]; tick();
    n_checks++;
    if (out_a !== 1'b1 || err_a !== 4'b0010 || cnt_a !== 8'd1) begin
      n_errors++; $display("FAIL rmid_setup: got out=%0b err=%b cnt=%0d, expected 1/0010/1", out_a, err_a, cnt_a);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_a !== 1'b0 || err_a !== 4'b0000 || cnt_a !== 8'd0) begin
      n_errors++; $display("FAIL rmid_async: got out=%0b err=%b cnt=%0d, expected 0/0000/0", out_a, err_a, cnt_a);
    end
    din = 4'b0000; gclk = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    gclk = ~gclk; tick();
    n_checks++;
    if (out_a !== 1'b0 || cnt_a !== 8'd1) begin
      n_errors++; $display("FAIL rmid_store_cleared: got out=%0b cnt=%0d, expected 0/1", out_a, cnt_a);
    end
  endtask

  initial begin
    test_reset();
    test_or_basic();
    test_function_sweep();
    test_double_pulse();
    test_simultaneous();
    test_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mitll_gaten_t.md
# mitll_gaten_t

Parametrised N-input clocked SFQ gate model for the cell library: a synchronous-RTL emulation of an RSFQ clocked gate whose data inputs, gate clock and output are toggle-encoded pulse lines, where each transition is one SFQ pulse. It generalises the two-input clocked OR to N channels with a runtime-selectable function (OR, AND, XOR, majority). It adds double-pulse detection and an evaluation counter. It sits between toggle-encoded pulse sources and sinks in system-level simulations that run on a conventional sampling clock.

## Interface
- N, default 4: number of data channels, 2..16.
- CW, default 8: width of evaluation counter.
- clk  in  1: sampling clock; all state updates on rising edge.
- rst_n  in  1: asynchronous, active-low reset.
- din  in  N: toggle-encoded data pulse lines, one per channel.
- gclk  in  1: toggle-encoded gate-clock pulse line.
- mode  in  2: function select; 0=OR, 1=AND, 2=XOR (odd parity), 3=majority (stored count > N/2, integer division).
- err_clr  in  1: synchronous clear of err_dbl.
- out  out  1: toggle-encoded output pulse line.
- err_dbl  out  N: sticky per-channel double-pulse flags.
- eval_cnt  out  CW: number of gclk pulses evaluated, wraps modulo 2^CW.

## Operation
- Pulse detection: registered copies din_q and gclk_q. A pulse on channel i is din[i] ^ din_q[i]; a gate-clock pulse is gclk ^ gclk_q. Each copy updates to the current value every cycle.
- Storage: the per-channel 1-bit store st[i] models the storing loop.
  - A data pulse sets st[i].
  - A data pulse on a channel whose st[i] is already 1, with no gclk pulse that cycle, is lost. It sets err_dbl[i] and leaves st[i]=1.
- Evaluation: on a gclk pulse, f is computed from st as held before this edge, using the mode sampled in the same cycle.
  - f=1 toggles out.
  - eval_cnt increments regardless of f.
  - All st bits clear, except channels with a data pulse in the same cycle.
- Simultaneous data pulse and gclk pulse in one cycle: the data pulse is excluded from the current evaluation and sets st[i] for the next period. This is never a double-pulse error.
- err_clr=1 clears all err_dbl bits at the edge. A new double pulse in the same cycle wins, so the bit stays 1.
- mode changes take effect at the next edge. Stored state is not disturbed.
- Reset (rst_n=0), at any time including mid-period:
  - out=0, err_dbl=0, eval_cnt=0, st=0, din_q=0, gclk_q=0, immediately.
  - Lines must be 0 at reset release. A line held at 1 across release registers one pulse on the first edge; this is the defined behaviour.

## Timing
- A pulse is recognised at the first rising clk edge that samples the new line level. Lines must not toggle twice within one clk period; that case is out of scope and undefined.
- out and eval_cnt change at the same edge that detects the gclk pulse: latency 1 edge from the gclk transition.
- err_dbl sets at the edge detecting the offending second pulse.
- eval_cnt wraps from 2^CW-1 to 0 without a flag.
- Outputs are registered only. There are no combinational paths from inputs to outputs.

## Test plan
- OR, N=4: pulse din[0] at cycle 2, gclk at cycle 5 -> out toggles 0→1 at edge 5 and eval_cnt=1. A second gclk with no data leaves out=1 and sets eval_cnt=2.
- Function sweep, stores {1,1,0,0} per mode:
  - OR -> toggle.
  - AND -> none; AND with {1,1,1,1} -> toggle.
  - XOR -> none; XOR with {1,0,0,0} -> toggle.
  - MAJ -> none, since 2 > 2 is false; MAJ with {1,1,1,0} -> toggle.
- Double pulse: din[2] pulsed at cycles 3 and 6, gclk at 8 -> err_dbl=4'b0100 from edge 6. OR evaluation toggles out once. err_clr at cycle 10 -> err_dbl=0.
- Simultaneous: din[1] and gclk in the same cycle with empty stores in OR mode -> no toggle at that edge. The next gclk toggles out.
- Wrap: CW=2 with 5 gclk pulses -> eval_cnt sequence 1,2,3,0,1.
- Reset mid-period: st={1,0,0,0} and out=1, then assert rst_n=0 between clk edges -> out=0, eval_cnt=0, err_dbl=0 immediately. After release, gclk alone in OR mode -> no toggle.
